// File: rtl/register_file_2p.sv
// Two-port (1W/1R) register file with registered read data + valid strobe,
// selectable read-during-write policy and optional post-reset zeroing sweep.
module register_file_2p #(
  parameter int unsigned DATA_WIDTH     = 24,
  parameter int unsigned ADDR_DEPTH     = 12,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter bit          BYPASS         = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  ready,
  input  logic                  wr_en,
  input  logic [ADDR_DEPTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_DEPTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int unsigned          DEPTH     = 2 ** ADDR_DEPTH;
  localparam logic [ADDR_DEPTH-1:0] LAST_ADDR = {ADDR_DEPTH{1'b1}};

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_DEPTH-1:0] r_sweep_cnt;
  logic                  r_ready;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_sweeping;
  logic                  w_user_wr;
  logic                  w_collide;
  logic                  w_mem_we;
  logic [ADDR_DEPTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [DATA_WIDTH-1:0] w_rd_value;

  // Single storage write port, shared between the clearing sweep and user writes
  always_comb begin
    w_sweeping  = CLEAR_ON_RESET && (r_state == ST_INIT);
    w_user_wr   = (r_state == ST_READY) && wr_en;
    w_collide   = wr_en && (wr_addr == rd_addr);
    w_mem_we    = w_sweeping || w_user_wr;
    w_mem_addr  = w_sweeping ? r_sweep_cnt : wr_addr;
    w_mem_wdata = w_sweeping ? '0 : wr_data;
    w_rd_value  = (BYPASS && w_collide) ? wr_data : r_mem[rd_addr];
  end

  // Storage has no reset; contents are defined only by the sweep or user writes
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Control FSM with registered ready and read outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_INIT;
      r_sweep_cnt <= '0;
      r_ready     <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (!CLEAR_ON_RESET || (r_sweep_cnt == LAST_ADDR)) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end
          if (CLEAR_ON_RESET) begin
            r_sweep_cnt <= r_sweep_cnt + ADDR_DEPTH'(1);
          end
        end
        ST_READY: begin
          if (rd_en) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= w_rd_value;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule
